// File: rtl/ws2812b_pkg.sv
// Timing constants, ns-to-cycles conversion and decoder state encoding shared by
// the WS2812B receiver and transmitter.
package ws2812b_pkg;

    localparam int unsigned H_MIN_NS = 32'd200;
    localparam int unsigned H_THR_NS = 32'd600;
    localparam int unsigned H_MAX_NS = 32'd1000;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } rx_state_t;

    // Round-to-nearest conversion, clamped so it always fits a 16-bit counter.
    function automatic logic [15:0] ns_to_cycles(input logic [63:0] clock_hz,
                                                 input logic [63:0] ns);
        logic [63:0] cyc;
        cyc = (clock_hz * ns + 64'd500_000_000) / 64'd1_000_000_000;
        if (cyc > 64'd65535) begin
            ns_to_cycles = 16'hFFFF;
        end else begin
            ns_to_cycles = cyc[15:0];
        end
    endfunction

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Two-flop synchronizer for the WS2812B line plus registered-history edge strobes.
module ws2812b_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability chain and one-cycle history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign din_s = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B serial decoder: pulse-width classification into 24-bit words with a
// valid/ready output, latch-gap detection and error reporting. Define
// WS2812B_RX_FWD_EN to add the chained-LED forwarding output dout.
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 32'd64_000_000,
    parameter int unsigned RES_NS   = 32'd50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        valid,
    input  logic        ready,
    output logic        latch,
    output logic        overrun,
    output logic        error
`ifdef WS2812B_RX_FWD_EN
    ,
    output logic        dout
`endif
);

    localparam logic [15:0] C_H_MIN = ns_to_cycles(64'(CLOCK_HZ), 64'(H_MIN_NS));
    localparam logic [15:0] C_H_THR = ns_to_cycles(64'(CLOCK_HZ), 64'(H_THR_NS));
    localparam logic [15:0] C_H_MAX = ns_to_cycles(64'(CLOCK_HZ), 64'(H_MAX_NS));
    localparam logic [15:0] C_RES   = ns_to_cycles(64'(CLOCK_HZ), 64'(RES_NS));
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic w_din_s;
    logic w_rise;
    logic w_fall;

    rx_state_t   r_state;
    rx_state_t   w_state_nx;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nx;
    logic [15:0] w_cnt_inc;
    // The 24th bit goes straight into data_out, so only 23 bits are held here.
    logic [22:0] r_shift;
    logic [22:0] w_shift_nx;
    logic [4:0]  r_bitcnt;
    logic [4:0]  w_bitcnt_nx;
    logic [23:0] r_data;
    logic [23:0] w_data_nx;
    logic        r_valid;
    logic        w_valid_nx;
    logic        r_overrun;
    logic        w_overrun_nx;
    logic        r_latch;
    logic        w_latch_nx;
    logic        r_error;
    logic        w_error_nx;
    logic        w_bit_val;
    logic        w_word_done;

    ws2812b_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .din_s (w_din_s),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // Next-state, datapath and output decode for the pulse-width decoder.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_shift_nx   = r_shift;
        w_bitcnt_nx  = r_bitcnt;
        w_data_nx    = r_data;
        w_valid_nx   = r_valid;
        w_overrun_nx = r_overrun;
        w_latch_nx   = 1'b0;
        w_error_nx   = 1'b0;
        w_bit_val    = 1'b0;
        w_word_done  = 1'b0;
        w_cnt_inc    = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + 16'd1);

        case (r_state)
            ST_SYNC: begin
                if (w_din_s) begin
                    w_cnt_nx = 16'd0;
                end else if (r_cnt >= C_RES) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 16'd0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nx = ST_HIGH;
                    w_cnt_nx   = 16'd1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if ((r_cnt > C_H_MAX) || (w_fall && (r_cnt < C_H_MIN))) begin
                    w_error_nx  = 1'b1;
                    w_state_nx  = ST_SYNC;
                    w_cnt_nx    = 16'd0;
                    w_shift_nx  = 23'd0;
                    w_bitcnt_nx = 5'd0;
                end else if (w_fall) begin
                    w_bit_val  = (r_cnt > C_H_THR);
                    w_state_nx = ST_LOW;
                    w_cnt_nx   = 16'd1;
                    if (r_bitcnt == 5'd23) begin
                        w_word_done = 1'b1;
                        w_shift_nx  = 23'd0;
                        w_bitcnt_nx = 5'd0;
                    end else begin
                        w_shift_nx  = {r_shift[21:0], w_bit_val};
                        w_bitcnt_nx = r_bitcnt + 5'd1;
                    end
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_state_nx = ST_HIGH;
                    w_cnt_nx   = 16'd1;
                end else if (r_cnt >= C_RES) begin
                    // A gap inside a word drops the partial word but is still a latch.
                    w_latch_nx  = 1'b1;
                    w_error_nx  = (r_bitcnt != 5'd0);
                    w_state_nx  = ST_IDLE;
                    w_cnt_nx    = 16'd0;
                    w_shift_nx  = 23'd0;
                    w_bitcnt_nx = 5'd0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            default: begin
                w_state_nx = ST_SYNC;
                w_cnt_nx   = 16'd0;
            end
        endcase

        if (w_word_done) begin
            w_data_nx    = {r_shift, w_bit_val};
            w_valid_nx   = 1'b1;
            w_overrun_nx = r_overrun | (r_valid & ~ready);
        end else if (r_valid && ready) begin
            w_valid_nx = 1'b0;
        end else begin
            w_valid_nx = r_valid;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_SYNC;
            r_cnt     <= 16'd0;
            r_shift   <= 23'd0;
            r_bitcnt  <= 5'd0;
            r_data    <= 24'd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_latch   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_shift   <= w_shift_nx;
            r_bitcnt  <= w_bitcnt_nx;
            r_data    <= w_data_nx;
            r_valid   <= w_valid_nx;
            r_overrun <= w_overrun_nx;
            r_latch   <= w_latch_nx;
            r_error   <= w_error_nx;
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;
    assign overrun  = r_overrun;
    assign latch    = r_latch;
    assign error    = r_error;

`ifdef WS2812B_RX_FWD_EN
    logic r_fwd;
    logic r_dout;
    logic w_frame_end;

    assign w_frame_end = w_latch_nx | w_error_nx;

    // Forwarding opens after the first word of a frame and closes at its end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd  <= 1'b0;
            r_dout <= 1'b0;
        end else begin
            if (w_frame_end) begin
                r_fwd <= 1'b0;
            end else if (w_word_done) begin
                r_fwd <= 1'b1;
            end else begin
                r_fwd <= r_fwd;
            end
            r_dout <= r_fwd & w_din_s & ~w_frame_end;
        end
    end

    assign dout = r_dout;
`endif

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed self-checking bench for ws2812b_rx at 64 MHz; bit timings are driven in
// whole clock cycles (0: 26 high/54 low, 1: 51 high/29 low).
`timescale 1ns/1ps
module tb_ws2812b_rx;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        din   = 1'b0;
    logic        ready = 1'b0;
    logic [23:0] data_out;
    logic        valid;
    logic        latch;
    logic        overrun;
    logic        error;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int latch_cnt = 0;
    int err_cnt   = 0;
    int l0;
    int e0;

    localparam logic [23:0] W1 = 24'hA5C30F;
    localparam logic [23:0] W2 = 24'h3C5A96;
    localparam logic [23:0] W3 = 24'h0F0F01;
    localparam int GAP = 3250;

`ifdef WS2812B_RX_FWD_EN
    logic       dout;
    logic [2:0] din_hist = 3'b000;
    logic       cmp_en   = 1'b0;
    int         dout_hi  = 0;
    int         dout_mis = 0;
    int         d0;
    int         m0;
    int         exp_hi;
    logic [23:0] wtmp;
`endif

    ws2812b_rx #(.CLOCK_HZ(64_000_000), .RES_NS(50_000)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .latch    (latch),
        .overrun  (overrun),
        .error    (error)
`ifdef WS2812B_RX_FWD_EN
        ,
        .dout     (dout)
`endif
    );

    always #7.812 clk = ~clk;

    always @(negedge clk) begin
        if (latch === 1'b1) latch_cnt <= latch_cnt + 1;
        if (error === 1'b1) err_cnt <= err_cnt + 1;
    end

`ifdef WS2812B_RX_FWD_EN
    always @(posedge clk) din_hist <= {din_hist[1:0], din};

    always @(negedge clk) begin
        if (dout === 1'b1) dout_hi <= dout_hi + 1;
        if (cmp_en && (dout !== din_hist[2])) dout_mis <= dout_mis + 1;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        repeat (b ? 51 : 26) @(negedge clk);
        din = 1'b0;
        repeat (b ? 29 : 54) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset values
        repeat (4) @(negedge clk);
        check("rst_data",    32'(data_out), 32'h0);
        check("rst_valid",   32'(valid),    32'h0);
        check("rst_latch",   32'(latch),    32'h0);
        check("rst_overrun", 32'(overrun),  32'h0);
        check("rst_error",   32'(error),    32'h0);
        rst = 1'b0;

        // Leaving SYNC after the first gap is silent
        l0 = latch_cnt;
        idle(GAP);
        check("sync_no_latch", 32'(latch_cnt - l0), 32'd0);

        // Single word; valid appears 3 clocks after the final pin fall
        send_bits(W1, 23);
        din = 1'b1;
        repeat (51) @(negedge clk);
        din = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("valid_at_2clk", 32'(valid), 32'h0);
        @(negedge clk);
        check("valid_at_3clk", 32'(valid), 32'h1);
        check("w1_data", 32'(data_out), 32'(W1));
        repeat (26) @(negedge clk);

        // Back-to-back word with ready low -> overwrite and overrun
        send_bits(W2, 24);
        check("ovr_data",    32'(data_out), 32'(W2));
        check("ovr_valid",   32'(valid),    32'h1);
        check("ovr_flag",    32'(overrun),  32'h1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("consume_valid", 32'(valid), 32'h0);
        l0 = latch_cnt;
        e0 = err_cnt;
        idle(GAP);
        check("frame_latch",    32'(latch_cnt - l0), 32'd1);
        check("frame_no_error", 32'(err_cnt - e0),   32'd0);
        check("ovr_sticky",     32'(overrun),        32'h1);

        // Reset clears overrun; ready held high -> no overrun
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("ovr_rst_clear", 32'(overrun), 32'h0);
        idle(GAP);
        ready = 1'b1;
        send_bits(W1, 24);
        send_bits(W2, 24);
        check("rdy_no_overrun", 32'(overrun),  32'h0);
        check("rdy_data",       32'(data_out), 32'(W2));
        check("rdy_valid",      32'(valid),    32'h0);
        idle(GAP);
        ready = 1'b0;

        // Partial word then latch gap
        l0 = latch_cnt;
        e0 = err_cnt;
        send_bits(W3, 12);
        idle(GAP);
        check("part_error", 32'(err_cnt - e0),   32'd1);
        check("part_latch", 32'(latch_cnt - l0), 32'd1);
        check("part_valid", 32'(valid),          32'h0);
        check("part_data",  32'(data_out),       32'(W2));

        // Too-short high pulse -> error, resync required
        e0 = err_cnt;
        din = 1'b1;
        repeat (10) @(negedge clk);
        idle(20);
        check("short_error", 32'(err_cnt - e0), 32'd1);
        send_bits(W1, 24);
        check("short_no_word", 32'(valid), 32'h0);
        l0 = latch_cnt;
        idle(GAP);
        check("resync_no_latch", 32'(latch_cnt - l0), 32'd0);

        // Too-long high pulse -> error, resync required
        e0 = err_cnt;
        din = 1'b1;
        repeat (77) @(negedge clk);
        idle(20);
        check("long_error", 32'(err_cnt - e0), 32'd1);
        send_bits(W1, 24);
        check("long_no_word", 32'(valid), 32'h0);
        idle(GAP);
        send_bits(W3, 24);
        check("resync_valid", 32'(valid),    32'h1);
        check("resync_data",  32'(data_out), 32'(W3));

        // Reset mid-word, then decode only after a full gap
        idle(GAP);
        send_bits(W2, 10);
        din = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data",    32'(data_out), 32'h0);
        check("mid_rst_valid",   32'(valid),    32'h0);
        check("mid_rst_overrun", 32'(overrun),  32'h0);
        check("mid_rst_latch",   32'(latch),    32'h0);
        check("mid_rst_error",   32'(error),    32'h0);
        send_bits(W1, 24);
        check("post_rst_no_word", 32'(valid), 32'h0);
        idle(GAP);
        send_bits(W2, 24);
        check("post_rst_valid", 32'(valid),    32'h1);
        check("post_rst_data",  32'(data_out), 32'(W2));

`ifdef WS2812B_RX_FWD_EN
        // Three-word frame: word 1 swallowed, words 2-3 forwarded
        idle(GAP);
        ready = 1'b1;
        d0 = dout_hi;
        send_bits(W1, 24);
        check("fwd_word1_quiet", 32'(dout_hi - d0), 32'd0);
        cmp_en = 1'b1;
        d0 = dout_hi;
        m0 = dout_mis;
        send_bits(W2, 24);
        send_bits(W3, 24);
        idle(GAP);
        exp_hi = 0;
        wtmp = W2;
        for (int i = 0; i < 24; i++) exp_hi += wtmp[i] ? 51 : 26;
        wtmp = W3;
        for (int i = 0; i < 24; i++) exp_hi += wtmp[i] ? 51 : 26;
        check("fwd_high_cycles", 32'(dout_hi - d0),  32'(exp_hi));
        check("fwd_mirror",      32'(dout_mis - m0), 32'd0);
        check("fwd_after_latch", 32'(dout),          32'h0);
        cmp_en = 1'b0;
        ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
